// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall/bubble/redirect controller with debug halt FSM for a 5-stage RV32 pipeline
//   in : clk, rst_n (sync, active-low), id_ld_use_i, ex_busy_i, mem_req_i, mem_ack_i,
//        br_taken_i, br_target_i[31:0], halt_req_i, resume_i
//   out: stall_o[4:0], bubble_o[4:0] (bit0 pc .. bit4 mem_wb), pc_load_o, pc_target_o[31:0],
//        halted_o, mem_timeout_o, stall_cnt_o[STALL_CNT_W-1:0]
module pipe_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_ld_use_i,
    input  logic                   ex_busy_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    input  logic                   br_taken_i,
    input  logic [31:0]            br_target_i,
    input  logic                   halt_req_i,
    input  logic                   resume_i,
    output logic [4:0]             stall_o,
    output logic [4:0]             bubble_o,
    output logic                   pc_load_o,
    output logic [31:0]            pc_target_o,
    output logic                   halted_o,
    output logic                   mem_timeout_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state, state_nx;
    logic [1:0] drain_cnt, drain_cnt_nx;
    logic [WW-1:0] wait_cnt;
    logic mem_wait, hold, hz_load;
    logic [4:0] hz_stall, hz_bubble;
    // a branch held under a mem/ex stall stays asserted in EX, so it only redirects once unstalled
    always_comb begin
        mem_wait  = mem_req_i & ~mem_ack_i;
        hold      = mem_wait | ex_busy_i;
        hz_load   = ~hold & br_taken_i;
        hz_stall  = mem_wait ? 5'b01111 : ex_busy_i ? 5'b00111 : br_taken_i ? 5'b00000 :
                    id_ld_use_i ? 5'b00011 : 5'b00000;
        hz_bubble = mem_wait ? 5'b10000 : ex_busy_i ? 5'b01000 : br_taken_i ? 5'b00110 :
                    id_ld_use_i ? 5'b00100 : 5'b00000;
    end
    always_comb begin
        stall_o      = '0;
        bubble_o     = '0;
        pc_load_o    = 1'b0;
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        if (rst_n) begin
            case (state)
                RUN: begin
                    stall_o   = hz_stall;
                    bubble_o  = hz_bubble;
                    pc_load_o = hz_load;
                    if (halt_req_i) begin
                        state_nx     = DRAIN;
                        drain_cnt_nx = 2'd0;
                    end
                end
                DRAIN: begin
                    // fetch is frozen and NOPs fed into if_id; load-use is moot since ID is being drained
                    stall_o   = 5'b00001 | (hold ? hz_stall : 5'b00000);
                    bubble_o  = 5'b00010 | (hold ? hz_bubble : hz_load ? 5'b00110 : 5'b00000);
                    pc_load_o = hz_load;
                    if (!hold) begin
                        if (br_taken_i) drain_cnt_nx = 2'd0;
                        else if (drain_cnt == 2'd3) state_nx = HALTED;
                        else drain_cnt_nx = drain_cnt + 2'd1;
                    end
                end
                HALTED: begin
                    stall_o = 5'b11111;
                    if (resume_i) state_nx = RUN;
                end
                default: state_nx = RUN;
            endcase
        end
        pc_target_o = pc_load_o ? br_target_i : 32'd0;
    end
    assign halted_o = rst_n && state == HALTED;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            drain_cnt     <= 2'd0;
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
            if (state != HALTED) begin
                wait_cnt <= mem_wait ? (wait_cnt == WW'(MEM_TIMEOUT) ? wait_cnt : wait_cnt + 1'b1) : '0;
                // set on the edge where the wait count reaches the limit
                if (mem_wait && wait_cnt >= WW'(MEM_TIMEOUT - 1)) mem_timeout_o <= 1'b1;
            end
            if (state == RUN && stall_o[0] && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random checks of pipe_ctrl against a rule-level reference model
module tb_pipe_ctrl;
    localparam int CW = 4;
    localparam int MEM_TO = 15;
    logic clk = 1'b0;
    logic rst_n, id_ld_use_i, ex_busy_i, mem_req_i, mem_ack_i, br_taken_i, halt_req_i, resume_i;
    logic [31:0] br_target_i;
    logic [4:0] stall_o, bubble_o;
    logic pc_load_o, halted_o, mem_timeout_o;
    logic [31:0] pc_target_o;
    logic [CW-1:0] stall_cnt_o;
    int errs = 0;
    int checks = 0;
    int m_mode, m_d, m_w, m_scnt;
    bit m_to;
    logic [4:0] e_s, e_b;
    logic e_l;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_CNT_W(CW), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst_n(rst_n), .id_ld_use_i(id_ld_use_i), .ex_busy_i(ex_busy_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
        .halted_o(halted_o), .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_ld_use_i = 0; ex_busy_i = 0; mem_req_i = 0; mem_ack_i = 0;
        br_taken_i = 0; br_target_i = 0; halt_req_i = 0; resume_i = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_d = 0; m_w = 0; m_scnt = 0; m_to = 0;
    endtask

    // mode: 0 run, 1 drain, 2 halted
    task automatic settle();
        bit mw;
        #3;
        mw = mem_req_i && !mem_ack_i;
        e_s = 0; e_b = 0; e_l = 0;
        if (rst_n) begin
            if (m_mode == 2) e_s = 5'h1F;
            else begin
                if (mw) begin e_s = 5'h0F; e_b = 5'h10; end
                else if (ex_busy_i) begin e_s = 5'h07; e_b = 5'h08; end
                else if (br_taken_i) begin e_b = 5'h06; e_l = 1; end
                else if (id_ld_use_i && m_mode == 0) begin e_s = 5'h03; e_b = 5'h04; end
                if (m_mode == 1) begin e_s[0] = 1; e_b[1] = 1; end
            end
        end
        chk("stall", stall_o, e_s);
        chk("bubble", bubble_o, e_b);
        chk("pc_load", pc_load_o, e_l);
        chk("pc_target", pc_target_o, e_l ? br_target_i : 0);
        chk("halted", halted_o, rst_n && m_mode == 2);
        chk("timeout", mem_timeout_o, m_to);
        chk("stall_cnt", stall_cnt_o, m_scnt);
    endtask

    task automatic tick();
        bit mw;
        mw = mem_req_i && !mem_ack_i;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (m_mode != 2) begin
                m_w = mw ? (m_w < MEM_TO ? m_w + 1 : m_w) : 0;
                if (m_w >= MEM_TO) m_to = 1;
            end
            if (m_mode == 0 && e_s[0] && m_scnt < (1 << CW) - 1) m_scnt++;
            case (m_mode)
                0: if (halt_req_i) begin m_mode = 1; m_d = 0; end
                1: if (!mw && !ex_busy_i) begin
                    if (br_taken_i) m_d = 0;
                    else if (m_d == 3) m_mode = 2;
                    else m_d++;
                end
                default: if (resume_i) m_mode = 0;
            endcase
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cyc();
        cyc();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        {id_ld_use_i, ex_busy_i, mem_req_i, mem_ack_i, br_taken_i, halt_req_i, resume_i} = '1;
        br_target_i = '1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        settle();
        chk("rst_stall", stall_o, 0);
        chk("rst_bubble", bubble_o, 0);
        tick();
        chk("rst_cnt", stall_cnt_o, 0);
        chk("rst_to", mem_timeout_o, 0);
        idle();
        rst_n = 1;
        cyc();
        // load-use, then load-use with a branch
        id_ld_use_i = 1;
        cyc();
        chk("lu_cnt", stall_cnt_o, 1);
        br_taken_i = 1; br_target_i = 32'h80;
        settle();
        chk("lu_br_target", pc_target_o, 32'h80);
        chk("lu_br_bubble", bubble_o, 5'b00110);
        tick();
        idle();
        cyc();
        // 16 memory-wait cycles, then ack
        mem_req_i = 1;
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk("mw_stall", stall_o, 5'b01111);
            tick();
            chk("mw_to", mem_timeout_o, i >= 15);
        end
        mem_ack_i = 1;
        cyc();
        idle();
        cyc();
        chk("to_sticky", mem_timeout_o, 1);
        // ex_busy holds a taken branch
        ex_busy_i = 1; br_taken_i = 1; br_target_i = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("pri_load_held", pc_load_o, 0);
            chk("pri_stall", stall_o, 5'b00111);
            tick();
        end
        ex_busy_i = 0;
        settle();
        chk("pri_load_go", pc_load_o, 1);
        tick();
        idle();
        // plain halt and resume
        halt_req_i = 1;
        cyc();
        halt_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_bits", {stall_o[0], bubble_o[1], halted_o}, 3'b110);
            tick();
        end
        settle();
        chk("halted", {halted_o, stall_o}, {1'b1, 5'b11111});
        tick();
        resume_i = 1;
        cyc();
        resume_i = 0;
        settle();
        chk("resumed", halted_o, 0);
        tick();
        // halt with a branch in the second drain cycle
        halt_req_i = 1;
        cyc();
        halt_req_i = 0;
        cyc();
        br_taken_i = 1; br_target_i = 32'h400;
        settle();
        chk("drain_br", pc_load_o, 1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("redrain", halted_o, 0);
            tick();
        end
        settle();
        chk("halt_after_br", halted_o, 1);
        tick();
        resume_i = 1;
        cyc();
        idle();
        // counter saturation
        do_reset();
        id_ld_use_i = 1;
        repeat (20) cyc();
        chk("sat", stall_cnt_o, 15);
        idle();
        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 99) != 0;
            id_ld_use_i = $urandom_range(0, 2) == 0;
            ex_busy_i = $urandom_range(0, 4) == 0;
            mem_req_i = $urandom_range(0, 1) == 0;
            mem_ack_i = $urandom_range(0, 3) == 0;
            br_taken_i = $urandom_range(0, 3) == 0;
            br_target_i = $urandom;
            halt_req_i = $urandom_range(0, 15) == 0;
            resume_i = $urandom_range(0, 5) == 0;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
